// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle for the HI/LO multiply-divide unit
interface muldiv_unit_if #(
    parameter int W = 32
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply / restoring divide unit with HI/LO registers
module muldiv_unit #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MADDU = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    // opnd holds the multiplicand magnitude for mul, the divisor magnitude for div
    logic [W-1:0]     opnd;
    // acc/sh: upper/lower product halves for mul, remainder/quotient for div
    logic [W-1:0]     acc;
    logic [W-1:0]     sh;
    logic             neg_lo;
    logic             neg_hi;

    logic             sgn_in;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic [W:0]       add_sum;
    logic [W:0]       trial;
    logic [W-1:0]     acc_nx;
    logic [W-1:0]     sh_nx;
    logic [2*W-1:0]   prod_mag;
    logic [2*W-1:0]   prod_res;
    logic [2*W-1:0]   madd_res;
    logic [W-1:0]     quo_res;
    logic [W-1:0]     rem_res;

    // Operand magnitudes for the incoming request; signed ops are the even opcodes
    always_comb begin
        sgn_in = ~bus.op[0];
        mag_a  = (sgn_in && bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
        mag_b  = (sgn_in && bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        add_sum = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        trial   = {acc, sh[W-1]} - {1'b0, opnd};
        acc_nx  = acc;
        sh_nx   = sh;
        if (!op_q[2]) begin
            acc_nx = add_sum[W:1];
            sh_nx  = {add_sum[0], sh[W-1:1]};
        end else if (!trial[W]) begin
            acc_nx = trial[W-1:0];
            sh_nx  = {sh[W-2:0], 1'b1};
        end else begin
            acc_nx = {acc[W-2:0], sh[W-1]};
            sh_nx  = {sh[W-2:0], 1'b0};
        end
    end

    // Sign correction and accumulation applied when leaving FIN
    always_comb begin
        prod_mag = {acc, sh};
        prod_res = neg_lo ? (~prod_mag + 1'b1) : prod_mag;
        madd_res = {bus.hi, bus.lo} + prod_res;
        quo_res  = neg_lo ? (~sh + 1'b1) : sh;
        rem_res  = neg_hi ? (~acc + 1'b1) : acc;
    end

    // Control FSM with registered status outputs and HI/LO architectural state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= OP_MULT;
            opnd         <= '0;
            acc          <= '0;
            sh           <= '0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MTHI: begin
                                bus.hi   <= bus.a;
                                bus.done <= 1'b1;
                            end
                            OP_MTLO: begin
                                bus.lo   <= bus.a;
                                bus.done <= 1'b1;
                            end
                            default: begin
                                if (bus.op[2] && (bus.b == '0)) begin
                                    bus.done     <= 1'b1;
                                    bus.div_zero <= 1'b1;
                                end else begin
                                    op_q     <= bus.op;
                                    cnt      <= CNT_LOAD;
                                    acc      <= '0;
                                    neg_lo   <= sgn_in & (bus.a[W-1] ^ bus.b[W-1]);
                                    neg_hi   <= sgn_in & bus.a[W-1];
                                    opnd     <= bus.op[2] ? mag_b : mag_a;
                                    sh       <= bus.op[2] ? mag_a : mag_b;
                                    bus.busy <= 1'b1;
                                    state    <= CALC;
                                end
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        acc <= acc_nx;
                        sh  <= sh_nx;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    if (!bus.flush) begin
                        bus.done <= 1'b1;
                        case (op_q)
                            OP_MULT, OP_MULTU: {bus.hi, bus.lo} <= prod_res;
                            OP_MADD, OP_MADDU: {bus.hi, bus.lo} <= madd_res;
                            OP_DIV, OP_DIVU: begin
                                bus.lo <= quo_res;
                                bus.hi <= rem_res;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   lat;
    int   bcnt;
    int   ndone;

    muldiv_unit_if #(.W(32)) bus ();

    muldiv_unit #(.W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max, output int l, output int bc);
        l  = 0;
        bc = 0;
        while (!bus.done && l < max) begin
            if (bus.busy) bc++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int bc);
        issue(op, a, b);
        wait_done(100, l, bc);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_dz", bus.div_zero, 0);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        rst = 1'b1;

        // MULTU 0xFFFFFFFF * 2
        run_op(3'b001, 32'hFFFF_FFFF, 32'd2, lat, bcnt);
        chk("multu_latency", lat, 33);
        chk("multu_busy_cycles", bcnt, 33);
        chk("multu_busy_in_done", bus.busy, 0);
        chk("multu_dz", bus.div_zero, 0);
        chk("multu_hi", bus.hi, 32'h0000_0001);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        // MULT -3 * 5, issued back-to-back in the done cycle
        run_op(3'b000, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        chk("mult_b2b_latency", lat, 33);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

        // MTHI / MTLO then MADDU 1*1 carries into HI
        run_op(3'b110, 32'h0, 32'h0, lat, bcnt);
        chk("mthi_latency", lat, 0);
        chk("mthi_busy", bus.busy, 0);
        chk("mthi_hi", bus.hi, 32'h0);
        run_op(3'b111, 32'hFFFF_FFFF, 32'h0, lat, bcnt);
        chk("mtlo_latency", lat, 0);
        chk("mtlo_lo", bus.lo, 32'hFFFF_FFFF);
        run_op(3'b011, 32'd1, 32'd1, lat, bcnt);
        chk("maddu_latency", lat, 33);
        chk("maddu_hi", bus.hi, 32'h0000_0001);
        chk("maddu_lo", bus.lo, 32'h0000_0000);

        // Signed divides
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("div_latency", lat, 33);
        chk("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        chk("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_7_m2_hi", bus.hi, 32'h0000_0001);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("div_ovf_dz", bus.div_zero, 0);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0);

        // DIVU by zero: immediate done with div_zero, HI/LO untouched
        run_op(3'b101, 32'd9, 32'd0, lat, bcnt);
        chk("divz_latency", lat, 0);
        chk("divz_done", bus.done, 1);
        chk("divz_flag", bus.div_zero, 1);
        chk("divz_busy", bus.busy, 0);
        chk("divz_hi", bus.hi, 32'h0);
        chk("divz_lo", bus.lo, 32'h8000_0000);
        @(posedge clk); #1;
        chk("divz_done_clear", bus.done, 0);
        chk("divz_flag_clear", bus.div_zero, 0);

        // DIVU 100 / 7
        run_op(3'b101, 32'd100, 32'd7, lat, bcnt);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);

        // start while busy is ignored
        issue(3'b000, 32'd3, 32'd4);
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(100, lat, bcnt);
        chk("ign_done_seen", bus.done, 1);
        chk("ign_hi", bus.hi, 32'h0);
        chk("ign_lo", bus.lo, 32'd12);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("ign_no_second_done", ndone, 0);
        chk("ign_lo_hold", bus.lo, 32'd12);

        // flush 10 cycles into DIVU
        issue(3'b101, 32'd1000, 32'd3);
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_done", bus.done, 0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("flush_no_done", ndone, 0);
        chk("flush_hi", bus.hi, 32'h0);
        chk("flush_lo", bus.lo, 32'd12);

        // flush in IDLE does not block start
        bus.flush = 1'b1;
        issue(3'b111, 32'h55, 32'h0);
        bus.flush = 1'b0;
        chk("idle_flush_done", bus.done, 1);
        chk("idle_flush_lo", bus.lo, 32'h55);

        // signed MADD: 10 + (-2 * 3) = 4
        run_op(3'b110, 32'h0, 32'h0, lat, bcnt);
        run_op(3'b111, 32'd10, 32'h0, lat, bcnt);
        run_op(3'b010, 32'hFFFF_FFFE, 32'd3, lat, bcnt);
        chk("madd_hi", bus.hi, 32'h0);
        chk("madd_lo", bus.lo, 32'd4);

        // asynchronous reset in the middle of a MADD
        issue(3'b010, 32'd7, 32'd7);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("rst_no_done", ndone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand width and HI/LO register width.
REQ-002 SHALL have parameter CNT_W, default 6, meaning iteration counter width; must satisfy 2^CNT_W > W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled at rising edges.
REQ-006 SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO.
REQ-007 SHALL have port a, input, W bits: operand A (multiplicand / dividend / MT source).
REQ-008 SHALL have port b, input, W bits: operand B (multiplier / divisor).
REQ-009 SHALL have port flush, input, 1 bit: synchronous abort of the in-flight operation.
REQ-010 SHALL have port busy, output, 1 bit: high while an iterative operation is in flight.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port div_zero, output, 1 bit: qualifies done; high when a DIV/DIVU had b == 0.
REQ-013 SHALL have port hi, output, W bits: architectural HI register.
REQ-014 SHALL have port lo, output, W bits: architectural LO register.

Function
REQ-015 SHALL implement states IDLE, CALC, FIN; busy = 1 exactly in CALC and FIN.
REQ-016 SHALL accept start only in IDLE; start in CALC/FIN is ignored with no effect on state, operands or op.
REQ-017 On acceptance of op 0xx or 10x with b != 0 (edge E0), SHALL latch a, b, op, load counter with W, and enter CALC.
REQ-018 CALC SHALL perform one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle on operand magnitudes, decrementing the counter; after W steps (edge E_W) it enters FIN.
REQ-019 At edge E_(W+1), FIN SHALL apply sign correction, write hi/lo, pulse done for one cycle, and return to IDLE.
REQ-020 Iterative latency SHALL be exactly W+1 cycles from accept edge to done-high cycle; hi/lo hold the new value in the done cycle.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the 2W-bit signed/unsigned product of a and b.
REQ-022 MADD/MADDU: {hi,lo} SHALL equal old {hi,lo} plus the 2W-bit signed/unsigned product, modulo 2^(2W).
REQ-023 DIV/DIVU: lo SHALL be the quotient truncated toward zero, hi the remainder with the sign of the dividend.
REQ-024 DIV of most-negative by -1 SHALL give lo = most-negative value, hi = 0, div_zero = 0.
REQ-025 DIV/DIVU with b == 0 SHALL not enter CALC; done and div_zero pulse in the cycle after E0; hi/lo unchanged.
REQ-026 MTHI/MTLO SHALL write a into hi/lo at E0, pulse done the following cycle, keep busy = 0.
REQ-027 div_zero SHALL be 0 whenever done is 0.
REQ-028 flush in CALC/FIN SHALL return to IDLE at that edge with no done and hi/lo unchanged; flush has priority over FIN completion; flush in IDLE has no effect and does not block start.
REQ-029 start asserted in the done cycle SHALL be accepted (back-to-back ops, no bubble).
REQ-030 The HI/LO value consumed by MADD SHALL be the value at FIN, including any immediately preceding op's result.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0, lo 0, aborting any in-flight op.
REQ-032 First start accepted SHALL be at the first rising edge with rst high.

Verification (W = 32)
REQ-033 MULTU a=0xFFFFFFFF b=2 -> done 33 cycles after accept, hi=0x00000001 lo=0xFFFFFFFE, busy high for 33 cycles.
REQ-034 MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; then MTHI 0, MTLO 0xFFFFFFFF, MADDU 1*1 -> hi=0x00000001 lo=0x00000000.
REQ-035 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=9 b=0 -> done+div_zero one cycle after accept, hi/lo unchanged.
REQ-036 start with MULTU 5*5 while busy with MULT 3*4 -> only MULT completes, hi=0 lo=12; back-to-back start in done cycle -> next op accepted.
REQ-037 flush 10 cycles into DIVU -> no done, busy drops next cycle, hi/lo unchanged; rst low mid-MADD -> hi=lo=0 and busy=0 immediately.
